// File: rtl/knn_topk_pkg.sv
// Shared definitions for the k-nearest-neighbour search peripheral:
// register map, STATUS fields, FSM encoding and derived datapath widths.
package knn_topk_pkg;

  localparam int A_CTRL        = 0;
  localparam int A_TEST_COORD  = 1;
  localparam int A_TRAIN_COORD = 2;
  localparam int A_TRAIN_LABEL = 3;
  localparam int A_STATUS      = 4;
  localparam int A_DIST_BASE   = 8;
  localparam int A_LABEL_BASE  = 16;

  localparam int ST_BUSY_BIT = 0;
  localparam int ST_CNT_LSB  = 8;
  localparam int ST_CNT_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_INSERT = 2'd2
  } state_t;

  function automatic int diff_width(input int coord_w);
    return coord_w + 1;
  endfunction

  function automatic int sq_width(input int coord_w);
    return 2 * coord_w + 2;
  endfunction

endpackage

// File: rtl/knn_topk_list.sv
// K-entry list kept sorted by ascending distance; stable for ties, empty
// entries sort last, and an insert beyond the last valid slot is dropped.
module knn_topk_list #(
  parameter int K       = 4,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 8,
  parameter int CNT_W   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 insert_i,
  input  logic [DATA_W-1:0]    dist_i,
  input  logic [LABEL_W-1:0]   label_i,
  output logic [K-1:0]         valid_o,
  output logic [K*DATA_W-1:0]  dist_o,
  output logic [K*LABEL_W-1:0] label_o,
  output logic [CNT_W-1:0]     count_o
);

  logic [K-1:0]       valid_q, valid_d;
  logic [DATA_W-1:0]  dist_q  [K];
  logic [DATA_W-1:0]  dist_d  [K];
  logic [LABEL_W-1:0] label_q [K];
  logic [LABEL_W-1:0] label_d [K];
  logic [CNT_W-1:0]   count_q, count_d;

  logic [K-1:0]       le_s;
  logic [K:0]         prev_le_s;
  logic [K-1:0]       up_valid_s;
  logic [DATA_W-1:0]  up_dist_s  [K];
  logic [LABEL_W-1:0] up_label_s [K];

  // Entry i keeps its value if it sorts at or before the new distance,
  // takes the new entry at the boundary, otherwise shifts down from i-1.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      le_s[i] = valid_q[i] && (dist_q[i] <= dist_i);
    end
    prev_le_s     = {le_s, 1'b1};
    up_valid_s[0] = 1'b1;
    up_dist_s[0]  = dist_i;
    up_label_s[0] = label_i;
    for (int i = 1; i < K; i++) begin
      up_valid_s[i] = valid_q[i-1];
      up_dist_s[i]  = dist_q[i-1];
      up_label_s[i] = label_q[i-1];
    end

    valid_d = valid_q;
    dist_d  = dist_q;
    label_d = label_q;
    count_d = count_q;
    if (clear_i) begin
      for (int i = 0; i < K; i++) begin
        valid_d[i] = 1'b0;
        dist_d[i]  = '1;
        label_d[i] = '0;
      end
      count_d = '0;
    end else if (insert_i && !le_s[K-1]) begin
      for (int i = 0; i < K; i++) begin
        if (le_s[i]) begin
          valid_d[i] = valid_q[i];
          dist_d[i]  = dist_q[i];
          label_d[i] = label_q[i];
        end else if (prev_le_s[i]) begin
          valid_d[i] = 1'b1;
          dist_d[i]  = dist_i;
          label_d[i] = label_i;
        end else begin
          valid_d[i] = up_valid_s[i];
          dist_d[i]  = up_dist_s[i];
          label_d[i] = up_label_s[i];
        end
      end
      count_d = (count_q < CNT_W'(K)) ? count_q + 1'b1 : count_q;
    end else begin
      count_d = count_q;
    end
  end

  // List storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < K; i++) begin
        valid_q[i] <= 1'b0;
        dist_q[i]  <= '1;
        label_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      dist_q  <= dist_d;
      label_q <= label_d;
      count_q <= count_d;
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_out
    assign dist_o[g*DATA_W +: DATA_W]    = dist_q[g];
    assign label_o[g*LABEL_W +: LABEL_W] = label_q[g];
  end
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/knn_topk.sv
// k-nearest-neighbour search peripheral: bus decode, coordinate pointers,
// distance FSM/accumulator. Define KNN_TOPK_L1_EN for the Manhattan metric.
module knn_topk
  import knn_topk_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int COORD_W = 16,
  parameter int N_DIM   = 2,
  parameter int K       = 4,
  parameter int LABEL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready
);

  localparam int DIFF_W = diff_width(COORD_W);
  localparam int SQ_W   = sq_width(COORD_W);
  localparam int SUM_W  = ((SQ_W > DATA_W) ? SQ_W : DATA_W) + 1;
  localparam int PTR_W  = (N_DIM > 1) ? $clog2(N_DIM) : 1;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    acc_q, acc_d;
  logic [PTR_W-1:0]     d_q, d_d;
  logic [PTR_W-1:0]     tptr_q, rptr_q;
  logic [COORD_W-1:0]   test_q  [N_DIM];
  logic [COORD_W-1:0]   train_q [N_DIM];
  logic [LABEL_W-1:0]   lab_q;
  logic                 ready_q;
  logic [DATA_W-1:0]    rdata_q;

  logic                 wr_s, busy_s, held_s, accept_s, we_s, commit_s, clear_s, ins_s;
  logic [DATA_W-1:0]    rd_s;
  logic [DIFF_W-1:0]    diff_s;
  logic [SQ_W-1:0]      term_s;
  logic [SUM_W-1:0]     sum_s;
  logic [DATA_W-1:0]    acc_sat_s;
  logic [K-1:0]         lvalid_s;
  logic [K*DATA_W-1:0]  ldist_s;
  logic [K*LABEL_W-1:0] llabel_s;
  logic [ST_CNT_W-1:0]  count_s;
  logic                 unused_ok_s;

  // Control-register writes wait for IDLE; reads and unmapped writes never stall.
  always_comb begin
    wr_s     = |wstrb;
    busy_s   = (state_q != S_IDLE);
    held_s   = valid && wr_s && (address <= ADDR_W'(A_TRAIN_LABEL)) && busy_s;
    accept_s = valid && !ready_q && !held_s;
    we_s     = accept_s && wr_s;
    commit_s = we_s && (address == ADDR_W'(A_TRAIN_LABEL));
    clear_s  = we_s && (address == ADDR_W'(A_CTRL)) && wdata[0];
  end

  // Read mux.
  always_comb begin
    rd_s = '0;
    if (address == ADDR_W'(A_STATUS)) begin
      rd_s[ST_BUSY_BIT]               = busy_s;
      rd_s[ST_CNT_LSB +: ST_CNT_W]    = count_s;
    end else begin
      rd_s = '0;
    end
    for (int i = 0; i < K; i++) begin
      if (address == ADDR_W'(A_DIST_BASE + i)) begin
        rd_s = ldist_s[i*DATA_W +: DATA_W];
      end else if (address == ADDR_W'(A_LABEL_BASE + i)) begin
        rd_s = DATA_W'(llabel_s[i*LABEL_W +: LABEL_W]);
      end else begin
        rd_s = rd_s;
      end
    end
  end

  // Bus response, coordinate storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      tptr_q  <= '0;
      rptr_q  <= '0;
      lab_q   <= '0;
      for (int i = 0; i < N_DIM; i++) begin
        test_q[i]  <= '0;
        train_q[i] <= '0;
      end
    end else begin
      ready_q <= accept_s;
      if (accept_s) begin
        rdata_q <= wr_s ? '0 : rd_s;
      end
      if (we_s && (address == ADDR_W'(A_TEST_COORD))) begin
        test_q[tptr_q] <= wdata[COORD_W-1:0];
        tptr_q <= (tptr_q == PTR_W'(N_DIM - 1)) ? '0 : tptr_q + 1'b1;
      end
      if (we_s && (address == ADDR_W'(A_TRAIN_COORD))) begin
        train_q[rptr_q] <= wdata[COORD_W-1:0];
        rptr_q <= (rptr_q == PTR_W'(N_DIM - 1)) ? '0 : rptr_q + 1'b1;
      end
      if (commit_s) begin
        lab_q  <= wdata[LABEL_W-1:0];
        rptr_q <= '0;
      end
    end
  end

  // Per-dimension distance term and saturating accumulate.
  always_comb begin
    diff_s = {train_q[d_q][COORD_W-1], train_q[d_q]} - {test_q[d_q][COORD_W-1], test_q[d_q]};
`ifdef KNN_TOPK_L1_EN
    term_s = diff_s[DIFF_W-1] ? SQ_W'(DIFF_W'(0) - diff_s) : SQ_W'(diff_s);
`else
    term_s = SQ_W'($signed(diff_s)) * SQ_W'($signed(diff_s));
`endif
    sum_s     = SUM_W'(acc_q) + SUM_W'(term_s);
    acc_sat_s = (|sum_s[SUM_W-1:DATA_W]) ? '1 : sum_s[DATA_W-1:0];
  end

  // FSM state register and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      d_q     <= d_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    d_d     = d_q;
    ins_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (commit_s) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          d_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        acc_d = acc_sat_s;
        if (d_q == PTR_W'(N_DIM - 1)) begin
          state_d = S_INSERT;
          d_d     = '0;
        end else begin
          d_d = d_q + 1'b1;
        end
      end
      S_INSERT: begin
        ins_s   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  knn_topk_list #(
    .K       (K),
    .DATA_W  (DATA_W),
    .LABEL_W (LABEL_W),
    .CNT_W   (ST_CNT_W)
  ) u_list (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (clear_s),
    .insert_i (ins_s),
    .dist_i   (acc_q),
    .label_i  (lab_q),
    .valid_o  (lvalid_s),
    .dist_o   (ldist_s),
    .label_o  (llabel_s),
    .count_o  (count_s)
  );

  assign unused_ok_s = ^{wdata[DATA_W-1:COORD_W], lvalid_s};
  assign ready = ready_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_knn_topk.sv
// Directed bench for knn_topk with a queue-based reference list model.
module tb_knn_topk;

  localparam int ADDR_W = 5, DATA_W = 32, COORD_W = 16, N_DIM = 2, K = 4, LABEL_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [3:0]        wstrb = '0;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  knn_topk #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .COORD_W(COORD_W),
             .N_DIM(N_DIM), .K(K), .LABEL_W(LABEL_W)) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_rdata = '0;
  bit          exp_on = 1'b0;
  string       exp_name = "";
  bit          prev_ready = 1'b0;

  typedef struct { longint d; int l; } ent_t;
  ent_t m_q[$];
  int   m_test [N_DIM];
  int   m_train[N_DIM];
  int   m_tptr = 0, m_rptr = 0;

  // Single compare process: every ready pulse, and read data when expected.
  always @(negedge clk) begin
    if (ready) begin
      checks++;
      if (prev_ready) begin
        errors++;
        $display("FAIL ready_pulse: ready high on consecutive cycles, required single-cycle pulse");
      end
      if (exp_on) begin
        checks++;
        if (rdata !== exp_rdata) begin
          errors++;
          $display("FAIL %s: got %h required %h", exp_name, rdata, exp_rdata);
        end
      end
    end
    prev_ready = ready;
  end

  task automatic xfer(input int addr, input int data, input bit wr,
                      input logic [31:0] exp, input bit chk, input string nm,
                      output int edges);
    address   = ADDR_W'(addr);
    wdata     = 32'(data);
    wstrb     = wr ? 4'hF : 4'h0;
    exp_rdata = exp;
    exp_on    = chk;
    exp_name  = nm;
    valid     = 1'b1;
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!ready && edges < 200);
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no ready after %0d cycles, required ready", nm, edges);
    end
    #1;
    valid  = 1'b0;
    wstrb  = 4'h0;
    exp_on = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    int e;
    xfer(addr, data, 1'b1, 32'h0, 1'b0, "write", e);
  endtask

  task automatic rd(input int addr, input logic [31:0] exp, input string nm);
    int e;
    xfer(addr, 0, 1'b0, exp, 1'b1, nm, e);
  endtask

  function automatic logic [31:0] m_reg(input int addr);
    if (addr == 4) return {20'd0, 4'(m_q.size()), 8'd0};
    if (addr >= 8 && addr < 8 + K)
      return (addr - 8 < m_q.size()) ? 32'(m_q[addr-8].d) : 32'hFFFF_FFFF;
    if (addr >= 16 && addr < 16 + K)
      return (addr - 16 < m_q.size()) ? 32'(m_q[addr-16].l) : 32'h0;
    return 32'h0;
  endfunction

  task automatic rdm(input int addr, input string nm);
    rd(addr, m_reg(addr), nm);
  endtask

  task automatic check_all();
    for (int i = 0; i < K; i++) begin
      rdm(8 + i, $sformatf("dist%0d", i));
      rdm(16 + i, $sformatf("label%0d", i));
    end
    rdm(4, "status");
  endtask

  task automatic w_test(input int v, output int edges);
    xfer(1, v, 1'b1, 32'h0, 1'b0, "test_coord", edges);
    m_test[m_tptr] = v;
    m_tptr = (m_tptr + 1) % N_DIM;
  endtask

  task automatic w_train(input int v);
    wr(2, v);
    m_train[m_rptr] = v;
    m_rptr = (m_rptr + 1) % N_DIM;
  endtask

  // Reference distance and sorted insert, straight from the list rules.
  task automatic commit(input int label, input bit wait_idle);
    longint acc = 0;
    int pos;
    ent_t e;
    wr(3, label);
    for (int d = 0; d < N_DIM; d++) begin
      longint df = longint'(m_train[d]) - longint'(m_test[d]);
`ifdef KNN_TOPK_L1_EN
      acc += (df < 0) ? -df : df;
`else
      acc += df * df;
`endif
      if (acc > 64'd4294967295) acc = 64'd4294967295;
    end
    m_rptr = 0;
    pos = m_q.size();
    for (int i = 0; i < m_q.size(); i++) begin
      if (m_q[i].d > acc) begin
        pos = i;
        break;
      end
    end
    if (pos < K) begin
      e.d = acc;
      e.l = label;
      m_q.insert(pos, e);
      if (m_q.size() > K) void'(m_q.pop_back());
    end
    if (wait_idle) repeat (N_DIM + 2) @(negedge clk);
  endtask

  task automatic point(input int x, input int y, input int label);
    w_train(x);
    w_train(y);
    commit(label, 1'b1);
  endtask

  task automatic clear_list();
    wr(0, 1);
    m_q.delete();
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < N_DIM; i++) begin
      m_test[i]  = 0;
      m_train[i] = 0;
    end
    m_tptr = 0;
    m_rptr = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e;
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Reset state
    rd(4, 32'h0, "reset_status");
    for (int i = 0; i < K; i++) begin
      rd(8 + i, 32'hFFFF_FFFF, $sformatf("reset_dist%0d", i));
      rd(16 + i, 32'h0, $sformatf("reset_label%0d", i));
    end

    // Single point (3,4) from origin, busy profile via STATUS reads
    w_test(0, e);
    w_test(0, e);
    w_train(3);
    w_train(4);
    commit(7, 1'b0);
    rd(4, 32'h0000_0001, "busy_status");
    rd(4, 32'h0000_0100, "idle_status");
`ifdef KNN_TOPK_L1_EN
    rd(8, 32'd7, "first_dist");
`else
    rd(8, 32'd25, "first_dist");
`endif
    rd(16, 32'd7, "first_label");
    check_all();

    // Five points with a tie and one dropped, then a discarded far point
    clear_list();
    point(1, 7, 1);
    point(1, 3, 2);
    point(2, 5, 3);
    point(3, 1, 4);
    point(6, 2, 5);
`ifdef KNN_TOPK_L1_EN
    rd(8, 32'd4, "five_d0");  rd(9, 32'd4, "five_d1");
    rd(10, 32'd7, "five_d2"); rd(11, 32'd8, "five_d3");
    rd(19, 32'd1, "five_l3");
`else
    rd(8, 32'd10, "five_d0");  rd(9, 32'd10, "five_d1");
    rd(10, 32'd29, "five_d2"); rd(11, 32'd40, "five_d3");
    rd(19, 32'd5, "five_l3");
`endif
    rd(16, 32'd2, "five_l0"); rd(17, 32'd4, "five_l1"); rd(18, 32'd3, "five_l2");
    rd(4, 32'h0000_0400, "five_count");
    point(9, 9, 6);
    check_all();

    // Unmapped accesses
    rd(5, 32'h0, "unmapped5");
    rd(31, 32'h0, "unmapped31");
    wr(6, 32'h1234);
    check_all();

    // Test-coordinate write right after a commit is held until IDLE
    clear_list();
    w_train(3);
    w_train(4);
    commit(9, 1'b0);
    w_test(100, e);
    checks++;
    if (e != N_DIM + 2) begin
      errors++;
      $display("FAIL held_write_latency: got %0d cycles required %0d", e, N_DIM + 2);
    end
    repeat (N_DIM + 2) @(negedge clk);
`ifdef KNN_TOPK_L1_EN
    rd(8, 32'd7, "held_dist");
`else
    rd(8, 32'd25, "held_dist");
`endif
    check_all();

    // Extreme coordinates: saturation (or L1 sum)
    clear_list();
    w_test(-32768, e);
    w_test(-32768, e);
    point(32767, 32767, 3);
`ifdef KNN_TOPK_L1_EN
    rd(8, 32'd131070, "extreme_dist");
`else
    rd(8, 32'hFFFF_FFFF, "extreme_dist");
`endif
    rd(4, 32'h0000_0100, "extreme_count");
    rd(16, 32'd3, "extreme_label");

    // Fill, then clear
    point(0, 0, 11);
    point(-32768, -32767, 12);
    point(100, -200, 13);
    point(5, 5, 14);
    check_all();
    clear_list();
    rd(4, 32'h0, "clear_status");
    check_all();

    // Reset asserted mid-ACCUM aborts the point
    w_train(1);
    w_train(2);
    commit(21, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);
    rd(4, 32'h0, "rst_status");
    rd(8, 32'hFFFF_FFFF, "rst_dist0");
    check_all();

    // Post-reset point: coordinates were zeroed
    point(1, 1, 5);
    rd(8, 32'd2, "post_rst_dist");
    rd(4, 32'h0000_0100, "post_rst_count");
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
